// File: rtl/ysyx_23060208_dsram_resp.sv
// Data-SRAM responder: slave end of the EXU data channel set (AW/W/B, AR/R).
// Latency: rvalid/bvalid rise 1+LAT(+0..3 random) cycles after the AR/W handshake.
// Backpressure: one transaction at a time; R/B responses are held until rready/bready.
// Ports: clk/rst (sync, active-low); AW/W/B write channels; AR/R read channel.
module ysyx_23060208_dsram_resp #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          AW         = 16,
  parameter int          READ_LAT   = 1,
  parameter int          WRITE_LAT  = 1,
  parameter int          RAND_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dsram_awaddr,
  input  logic        dsram_awvalid,
  output logic        dsram_awready,
  input  logic [31:0] dsram_wdata,
  input  logic [2:0]  dsram_wstrb,
  input  logic        dsram_wvalid,
  output logic        dsram_wready,
  output logic [1:0]  dsram_bresp,
  output logic        dsram_bvalid,
  input  logic        dsram_bready,
  input  logic [31:0] dsram_araddr,
  input  logic        dsram_arvalid,
  output logic        dsram_arready,
  output logic [31:0] dsram_rdata,
  output logic [1:0]  dsram_rresp,
  output logic        dsram_rvalid,
  input  logic        dsram_rready
);
  typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, B_RESP} state_t;

  // Size of the mapped window in bytes; offsets at or above this are out of range.
  localparam logic [32:0] SPAN = 33'(1) << (AW + 2);

  state_t      state;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [2:0]  wsz;
  logic [4:0]  cnt;
  logic [3:0]  lfsr;
  logic        rvalid_q;
  logic        bvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [1:0]  bresp_q;

  logic [31:0] mem [2**AW];

  // Delay for the transaction being accepted this cycle (pre-step LFSR value).
  logic [4:0] extra;
  logic [4:0] rd_delay;
  logic [4:0] wr_delay;
  logic [3:0] lfsr_next;
  assign extra     = (RAND_DELAY != 0) ? {3'b000, lfsr[1:0]} : 5'd0;
  assign rd_delay  = 5'(READ_LAT) + extra;
  assign wr_delay  = 5'(WRITE_LAT) + extra;
  assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

  // Read path: in IDLE the zero-delay case must use the live address.
  logic [31:0] rd_addr;
  logic [31:0] rd_off;
  logic [31:0] rd_word;
  logic [31:0] rd_data;
  logic        rd_ok;
  assign rd_addr = (state == IDLE) ? dsram_araddr : addr;
  // Offset below BASE wraps to a huge value, so one compare covers both bounds.
  assign rd_off  = rd_addr - BASE;
  assign rd_ok   = ({1'b0, rd_off} < SPAN);
  assign rd_word = mem[rd_off[AW+1:2]];
  assign rd_data = rd_ok ? (rd_word >> {rd_addr[1:0], 3'b000}) : 32'd0;

  // Write path: in W_DATA the zero-delay case must use the live data/size.
  logic [31:0] wr_off;
  logic [31:0] wr_dat;
  logic [31:0] wr_old;
  logic [31:0] wr_mask;
  logic [31:0] wr_ins;
  logic [2:0]  wr_sz;
  logic        wr_ok;
  logic        wr_fire;
  assign wr_dat = (state == W_DATA) ? dsram_wdata : wdat;
  assign wr_sz  = (state == W_DATA) ? dsram_wstrb : wsz;
  assign wr_off = addr - BASE;
  assign wr_old = mem[wr_off[AW+1:2]];

  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_ins  = wr_dat;
    wr_ok   = 1'b0;
    case (wr_sz)
      3'b001: begin
        wr_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
        wr_ins  = {24'd0, wr_dat[7:0]} << {addr[1:0], 3'b000};
        wr_ok   = 1'b1;
      end
      3'b010: begin
        wr_mask = 32'h0000_FFFF << {addr[1], 4'b0000};
        wr_ins  = {16'd0, wr_dat[15:0]} << {addr[1], 4'b0000};
        wr_ok   = !addr[0];
      end
      3'b100:  wr_ok = (addr[1:0] == 2'b00);
      default: wr_ok = 1'b0;
    endcase
    wr_ok = wr_ok && ({1'b0, wr_off} < SPAN);
  end

  // Commit point: W handshake with zero delay, or the last W_WAIT cycle.
  assign wr_fire = rst && wr_ok &&
                   (((state == W_DATA) && dsram_wvalid && (wr_delay == 5'd0)) ||
                    ((state == W_WAIT) && (cnt == 5'd0)));

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_off[AW+1:2]] <= (wr_old & ~wr_mask) | (wr_ins & wr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lfsr     <= 4'b1001;
      addr     <= 32'd0;
      wdat     <= 32'd0;
      wsz      <= 3'd0;
      cnt      <= 5'd0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
      bresp_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (dsram_arvalid) begin
            addr <= dsram_araddr;
            lfsr <= lfsr_next;
            if (rd_delay == 5'd0) begin
              rdata_q  <= rd_data;
              rresp_q  <= {!rd_ok, 1'b0};
              rvalid_q <= 1'b1;
              state    <= R_RESP;
            end else begin
              cnt   <= rd_delay - 5'd1;
              state <= R_WAIT;
            end
          end else if (dsram_awvalid) begin
            addr  <= dsram_awaddr;
            state <= W_DATA;
          end
        end
        R_WAIT: begin
          if (cnt == 5'd0) begin
            rdata_q  <= rd_data;
            rresp_q  <= {!rd_ok, 1'b0};
            rvalid_q <= 1'b1;
            state    <= R_RESP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        R_RESP: begin
          if (dsram_rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        W_DATA: begin
          if (dsram_wvalid) begin
            wdat <= dsram_wdata;
            wsz  <= dsram_wstrb;
            lfsr <= lfsr_next;
            if (wr_delay == 5'd0) begin
              bresp_q  <= {!wr_ok, 1'b0};
              bvalid_q <= 1'b1;
              state    <= B_RESP;
            end else begin
              cnt   <= wr_delay - 5'd1;
              state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (cnt == 5'd0) begin
            bresp_q  <= {!wr_ok, 1'b0};
            bvalid_q <= 1'b1;
            state    <= B_RESP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        B_RESP: begin
          if (dsram_bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low for the whole time rst is held, not just after the edge.
  assign dsram_arready = rst && (state == IDLE);
  assign dsram_awready = rst && (state == IDLE) && !dsram_arvalid;
  assign dsram_wready  = rst && (state == W_DATA);
  assign dsram_rvalid  = rst && rvalid_q;
  assign dsram_bvalid  = rst && bvalid_q;
  assign dsram_rdata   = rst ? rdata_q : 32'd0;
  assign dsram_rresp   = rst ? rresp_q : 2'b00;
  assign dsram_bresp   = rst ? bresp_q : 2'b00;

endmodule

// File: tb/tb_ysyx_23060208_dsram_resp.sv
// Bench for ysyx_23060208_dsram_resp: drivers issue AR/AW/W and push expectations,
// a negedge monitor pops and compares R/B responses and first-valid latency.
// Reference model is a byte-addressed associative array.
module tb_ysyx_23060208_dsram_resp;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int AW = 16;
  localparam int READ_LAT = 1;
  localparam int WRITE_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [2:0]  wstrb = 0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  ysyx_23060208_dsram_resp #(
    .BASE(BASE), .AW(AW), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .RAND_DELAY(0)
  ) dut (
    .clk(clk), .rst(rst),
    .dsram_awaddr(awaddr), .dsram_awvalid(awvalid), .dsram_awready(awready),
    .dsram_wdata(wdata), .dsram_wstrb(wstrb), .dsram_wvalid(wvalid), .dsram_wready(wready),
    .dsram_bresp(bresp), .dsram_bvalid(bvalid), .dsram_bready(bready),
    .dsram_araddr(araddr), .dsram_arvalid(arvalid), .dsram_arready(arready),
    .dsram_rdata(rdata), .dsram_rresp(rresp), .dsram_rvalid(rvalid), .dsram_rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;
  exp_t rq[$];
  exp_t bq[$];

  logic [7:0] mbyte [int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: no handshake within 100 cycles, required one", nm);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) &&
           (longint'(a) < longint'(BASE) + 4 * (longint'(1) << AW));
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [2:0] s);
    int n;
    case (s)
      3'b001:  n = 1;
      3'b010:  n = 2;
      3'b100:  n = 4;
      default: n = 0;
    endcase
    if (n == 0 || !in_rng(a) || (int'(a[1:0]) % n) != 0) return 2'b10;
    for (int i = 0; i < n; i++) mbyte[a + i] = d[8*i +: 8];
    return 2'b00;
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'd0;
    r = 2'b10;
    if (in_rng(a)) begin
      r = 2'b00;
      for (int i = 0; i < 4 - int'(a[1:0]); i++) d[8*i +: 8] = mbyte[a + i];
    end
  endtask

  // Monitor: compares every cycle a response is presented, pops on handshake.
  bit prev_r = 0, prev_b = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_r = 0;
      prev_b = 0;
    end else begin
      if (rvalid) begin
        if (rq.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
        else begin
          chk("rdata", rdata, rq[0].data);
          chk("rresp", 32'(rresp), 32'(rq[0].resp));
          if (!prev_r) chk("r_latency", 32'(cyc), 32'(rq[0].due));
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
        else begin
          chk("bresp", 32'(bresp), 32'(bq[0].resp));
          if (!prev_b) chk("b_latency", 32'(cyc), 32'(bq[0].due));
          if (bready) void'(bq.pop_front());
        end
      end
      prev_r = rvalid;
      prev_b = bvalid;
    end
  end

  task automatic do_read(input logic [31:0] a, input int bp, output int done_cyc);
    exp_t e;
    int n;
    done_cyc = -1;
    @(posedge clk); #1;
    arvalid = 1; araddr = a;
    n = 0;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) begin tmo("ar_handshake"); arvalid = 0; return; end
    model_read(a, e.data, e.resp);
    e.due = cyc + 1 + READ_LAT;
    rq.push_back(e);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin tmo("r_valid"); return; end
    repeat (bp) begin @(posedge clk); #1; end
    rready = 1;
    done_cyc = cyc;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                          input int bp, input bit abort, output int aw_cyc);
    exp_t e;
    int n;
    aw_cyc = -1;
    @(posedge clk); #1;
    awvalid = 1; awaddr = a;
    n = 0;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) begin tmo("aw_handshake"); awvalid = 0; return; end
    aw_cyc = cyc;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 1; wdata = d; wstrb = s;
    @(negedge clk);
    chk("wready_after_aw", 32'(wready), 32'd1);
    n = 0;
    while (!wready && n < 100) begin @(negedge clk); n++; end
    if (!wready) begin tmo("w_handshake"); wvalid = 0; return; end
    if (abort) begin
      @(posedge clk); #1;
      wvalid = 0;
      return;
    end
    e.data = 32'd0;
    e.resp = model_write(a, d, s);
    e.due = cyc + 1 + WRITE_LAT;
    bq.push_back(e);
    @(posedge clk); #1;
    wvalid = 0;
    n = 0;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin tmo("b_valid"); return; end
    repeat (bp) begin @(posedge clk); #1; end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"},  32'(wready),  32'd0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
    chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
    chk({tag, "_rresp"},   32'(rresp),   32'd0);
    chk({tag, "_bresp"},   32'(bresp),   32'd0);
    chk({tag, "_rdata"},   rdata,        32'd0);
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 2))
        0:       return BASE - 32'd4;
        1:       return BASE + 32'h0004_0000;
        default: return 32'h0000_1000;
      endcase
    end
    return BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [2:0] pick_sz();
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 2))
        0:       return 3'b000;
        1:       return 3'b011;
        default: return 3'b110;
      endcase
    end
    case ($urandom_range(0, 2))
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  initial begin
    int awc, rdone;
    logic [31:0] ra;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("arready_after_reset", 32'(arready), 32'd1);

    // Directed: word store/load, byte merge, shifted read.
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 3'b100, 0, 0, awc);
    do_read(BASE + 32'h10, 0, rdone);
    do_write(BASE + 32'h13, 32'h0000_0055, 3'b001, 0, 0, awc);
    do_read(BASE + 32'h10, 0, rdone);
    do_read(BASE + 32'h12, 0, rdone);

    // Illegal accesses leave memory untouched.
    do_write(BASE + 32'h11, 32'h0000_1234, 3'b010, 0, 0, awc);
    do_read(32'h7FFF_FFFC, 0, rdone);
    do_read(BASE + 32'h10, 0, rdone);

    // Range boundary: last legal word and first illegal one.
    do_write(BASE + 32'h0003_FFFC, 32'hCAFE_F00D, 3'b100, 0, 0, awc);
    do_read(BASE + 32'h0003_FFFE, 0, rdone);
    do_write(BASE + 32'h0004_0000, 32'h1111_2222, 3'b100, 0, 0, awc);
    do_read(BASE + 32'h0004_0000, 0, rdone);

    // Read backpressure.
    do_read(BASE + 32'h10, 5, rdone);

    // Simultaneous AR and AW: read wins, write follows.
    fork
      do_read(BASE + 32'h10, 0, rdone);
      do_write(BASE + 32'h20, 32'h1234_5678, 3'b100, 0, 0, awc);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("awready_while_arvalid", 32'(awready), 32'd0);
      end
    join
    chk("aw_after_r_done", 32'(awc > rdone), 32'd1);
    do_read(BASE + 32'h20, 0, rdone);

    // Reset during W_WAIT abandons the store.
    do_write(BASE + 32'h10, 32'hA5A5_A5A5, 3'b100, 0, 1, awc);
    rst = 0;
    @(negedge clk);
    chk_all_zero("rst_wwait");
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("arready_after_release", 32'(arready), 32'd1);
    do_read(BASE + 32'h10, 0, rdone);

    // Fill the random window, then random traffic.
    for (int k = 0; k < 16; k++)
      do_write(BASE + 32'h100 + 32'(4 * k), $urandom, 3'b100, 0, 0, awc);
    for (int k = 0; k < 200; k++) begin
      ra = pick_addr();
      if ($urandom_range(0, 1) == 0) do_read(ra, $urandom_range(0, 3), rdone);
      else do_write(ra, $urandom, pick_sz(), $urandom_range(0, 3), 0, awc);
    end

    repeat (5) @(negedge clk);
    chk("r_queue_drained", 32'(rq.size()), 32'd0);
    chk("b_queue_drained", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required $finish");
    $fatal(1, "timeout");
  end
endmodule
